// File: rtl/mod_74x165_serial_tx_pkg.sv
// Shared definitions for the 74x165-style serial transmitter:
// FSM state encoding and the bit-counter width helper.
package mod_74x165_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  // Counter must hold 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    if (width <= 2)
      return 1;
    else
      return $clog2(width);
  endfunction

endpackage

// File: rtl/mod_74x165_serial_tx_if.sv
// Load handshake, shift control and serial output bundle of the transmitter.
// master = the word source / link consumer side, slave = the transmitter.
interface mod_74x165_serial_tx_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [0:WIDTH-1] D;
  logic             LOAD_VALID;
  logic             LOAD_READY;
  logic             INH;
  logic             SER;
  logic             QH;
  logic             QH_N;
  logic             BUSY;
  logic             DONE;

  modport master (
    output D, LOAD_VALID, INH, SER,
    input  LOAD_READY, QH, QH_N, BUSY, DONE
  );

  modport slave (
    input  D, LOAD_VALID, INH, SER,
    output LOAD_READY, QH, QH_N, BUSY, DONE
  );

endinterface

// File: rtl/mod_74x165_serial_tx_shreg.sv
// Pure WIDTH-bit parallel-load shift register (74x165 core).
// Bit 0 is the MSB as in the [0:N] vectors; MSB_FIRST picks which end
// drives QH and which end receives SER.
module mod_74x165_shreg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             LOAD,
  input  logic             SHIFT_EN,
  input  logic             SER,
  input  logic [0:WIDTH-1] D,
  output logic             QH
);

  logic [0:WIDTH-1] sr;

  // Synchronous clear, parallel load has priority over shifting.
  always_ff @(posedge CLK) begin
    if (!CLR_N)
      sr <= '0;
    else if (LOAD)
      sr <= D;
    else if (SHIFT_EN) begin
      if (MSB_FIRST)
        sr <= {sr[1:WIDTH-1], SER};
      else
        sr <= {SER, sr[0:WIDTH-2]};
    end
  end

  assign QH = MSB_FIRST ? sr[0] : sr[WIDTH-1];

endmodule

// File: rtl/mod_74x165_serial_tx.sv
// Parallel-in / serial-out transmitter: valid/ready word load, one bit per
// non-inhibited clock, BUSY framing and a one-cycle DONE after the last bit.
module mod_74x165_serial_tx
  import mod_74x165_serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                     CLK,
  input logic                     CLR_N,
  mod_74x165_serial_tx_if.slave   bus
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load_ready;
  logic          busy;
  logic          done;
  logic          load;
  logic          shift_en;
  logic          qh;

  // Register control: load only when idle; the final bit is held (no shift)
  // on the edge that moves to FIN so QH keeps presenting it.
  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    if (state == ST_IDLE)
      load = bus.LOAD_VALID;
    if (state == ST_SHIFT)
      shift_en = !bus.INH && (cnt != LAST);
  end

  // Frame FSM with counter and registered handshake/framing outputs.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.LOAD_VALID) begin
            state      <= ST_SHIFT;
            cnt        <= '0;
            load_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!bus.INH) begin
            if (cnt == LAST) begin
              state <= ST_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_FIN: begin
          state      <= ST_IDLE;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          cnt        <= '0;
          load_ready <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

  mod_74x165_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .CLK      (CLK),
    .CLR_N    (CLR_N),
    .LOAD     (load),
    .SHIFT_EN (shift_en),
    .SER      (bus.SER),
    .D        (bus.D),
    .QH       (qh)
  );

  assign bus.LOAD_READY = load_ready;
  assign bus.BUSY       = busy;
  assign bus.DONE       = done;
  assign bus.QH         = qh;
  assign bus.QH_N       = ~qh;

endmodule

// File: tb/tb_mod_74x165_serial_tx.sv
// Directed bench for mod_74x165_serial_tx: an 8-bit MSB-first instance plus
// a 4-bit LSB-first instance, expected values hand-derived per cycle.
module tb_mod_74x165_serial_tx;

  logic clk = 1'b0;
  logic clr_n;

  always #5 clk = ~clk;

  mod_74x165_serial_tx_if #(.WIDTH(8)) bus ();
  mod_74x165_serial_tx_if #(.WIDTH(4)) bus4 ();

  mod_74x165_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .CLK   (clk),
    .CLR_N (clr_n),
    .bus   (bus)
  );

  mod_74x165_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
    .CLK   (clk),
    .CLR_N (clr_n),
    .bus   (bus4)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic lr, input logic qh,
                           input logic bsy, input logic dn);
    check($sformatf("%s.ready", tag), bus.LOAD_READY, lr);
    check($sformatf("%s.qh",    tag), bus.QH,         qh);
    check($sformatf("%s.qh_n",  tag), bus.QH_N,       ~qh);
    check($sformatf("%s.busy",  tag), bus.BUSY,       bsy);
    check($sformatf("%s.done",  tag), bus.DONE,       dn);
  endtask

  task automatic accept(input string tag, input logic [0:7] w);
    bus.D          = w;
    bus.LOAD_VALID = 1'b1;
    check($sformatf("%s.acc_ready", tag), bus.LOAD_READY, 1'b1);
    step();
    bus.LOAD_VALID = 1'b0;
  endtask

  // Checks cycles 1..8 after accept, the FIN cycle and the return to IDLE.
  task automatic shift_out(input string tag, input logic [0:7] w,
                           input int unsigned hold_idx, input int unsigned hold_n,
                           input bit swap, input logic [0:7] new_d);
    for (int unsigned i = 0; i < 8; i++) begin
      int unsigned hold;
      hold = (i == hold_idx) ? hold_n : 32'd0;
      for (int unsigned h = 0; h <= hold; h++) begin
        check_out($sformatf("%s.b%0d_%0d", tag, i, h), 1'b0, w[i], 1'b1, 1'b0);
        bus.INH = (h < hold);
        if (swap && i == 4) bus.D = new_d;
        step();
      end
    end
    bus.INH = 1'b0;
    check_out($sformatf("%s.fin", tag), 1'b0, w[7], 1'b0, 1'b1);
    step();
    check_out($sformatf("%s.idle", tag), 1'b1, w[7], 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:3] w4;
    bus.D = '0;  bus.LOAD_VALID = 1'b0;  bus.INH = 1'b0;  bus.SER = 1'b0;
    bus4.D = '0; bus4.LOAD_VALID = 1'b0; bus4.INH = 1'b0; bus4.SER = 1'b1;
    clr_n = 1'b0;

    // Reset with a valid word presented: nothing may load.
    bus.D = 8'hA5;
    bus.LOAD_VALID = 1'b1;
    step();
    step();
    check_out("rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst4.ready", bus4.LOAD_READY, 1'b1);
    check("rst4.qh",    bus4.QH,         1'b0);
    check("rst4.qh_n",  bus4.QH_N,       1'b1);
    clr_n = 1'b1;
    bus.LOAD_VALID = 1'b0;
    step();
    check_out("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0);

    // Basic frame.
    accept("basic", 8'b1011_0010);
    shift_out("basic", 8'b1011_0010, 99, 0, 1'b0, 8'h00);

    // Bit 3 held for three inhibited edges.
    accept("inh", 8'b1011_0010);
    shift_out("inh", 8'b1011_0010, 3, 3, 1'b0, 8'h00);

    // Cascade fill with SER=0, then an all-zero frame.
    bus.SER = 1'b0;
    accept("ff", 8'hFF);
    shift_out("ff", 8'hFF, 99, 0, 1'b0, 8'h00);
    accept("zero", 8'h00);
    shift_out("zero", 8'h00, 99, 0, 1'b0, 8'h00);

    // LOAD_VALID held through the frame; D changes mid-frame.
    bus.D = 8'h3C;
    bus.LOAD_VALID = 1'b1;
    step();
    shift_out("hs1", 8'h3C, 99, 0, 1'b1, 8'hC3);
    step();
    bus.LOAD_VALID = 1'b0;
    shift_out("hs2", 8'hC3, 99, 0, 1'b0, 8'h00);

    // Reset after the 4th bit is shown.
    accept("abort", 8'b1011_0010);
    check_out("abort.b0", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check_out("abort.b1", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_out("abort.b2", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check_out("abort.b3", 1'b0, 1'b1, 1'b1, 1'b0);
    clr_n = 1'b0;
    step();
    check_out("abort.rst", 1'b1, 1'b0, 1'b0, 1'b0);
    clr_n = 1'b1;
    step();
    check_out("abort.after", 1'b1, 1'b0, 1'b0, 1'b0);
    accept("p81", 8'h81);
    shift_out("p81", 8'h81, 99, 0, 1'b0, 8'h00);

    // LSB-first 4-bit instance: D[3] leaves first.
    w4 = 4'b1000;
    bus4.D = w4;
    bus4.LOAD_VALID = 1'b1;
    check("lsb.acc_ready", bus4.LOAD_READY, 1'b1);
    step();
    bus4.LOAD_VALID = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      check($sformatf("lsb.b%0d.qh", i),   bus4.QH,   w4[3-i]);
      check($sformatf("lsb.b%0d.busy", i), bus4.BUSY, 1'b1);
      check($sformatf("lsb.b%0d.done", i), bus4.DONE, 1'b0);
      step();
    end
    check("lsb.fin.done", bus4.DONE, 1'b1);
    check("lsb.fin.qh",   bus4.QH,   w4[0]);
    check("lsb.fin.busy", bus4.BUSY, 1'b0);
    step();
    check("lsb.idle.ready", bus4.LOAD_READY, 1'b1);
    check("lsb.idle.done",  bus4.DONE,       1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
